// File: rtl/psone_pad.sv
// PlayStation digital-pad responder on the console ATT/CLK/CMD/DAT/ACK link.
// Answers the 01/42 poll with ID, 0x5A and two button bytes; reports motor bytes.
module psone_pad #(
  parameter logic [7:0] PAD_ID    = 8'h41,
  parameter int         ACK_DELAY = 150,
  parameter int         ACK_WIDTH = 100
) (
  input  logic        iCLK,
  input  logic        iRESET,
  input  logic        iATT,
  input  logic        iPCLK,
  input  logic        iCMD,
  input  logic [15:0] iBTN,
  output logic        oDAT,
  output logic        oACK,
  output logic        oPOLL,
  output logic [15:0] oMOTOR,
  output logic        oERR,
  output logic        oBUSY
);

  localparam int ACK_MAX = (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
  localparam int CW      = $clog2(ACK_MAX + 1);
  localparam logic [CW-1:0] DELAY_LAST = CW'(ACK_DELAY - 1);
  localparam logic [CW-1:0] WIDTH_LAST = CW'(ACK_WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [2:0] {IDLE, SHIFT, ACK_WAIT, ACK_PULSE, IGNORE} state_t;

  // Bits [0],[1] synchronize the pin; bit [2] is the previous synchronized value for edge detection
  logic [2:0] attSync_q, pclkSync_q;
  logic [1:0] cmdSync_q;

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      attSync_q  <= '1;
      pclkSync_q <= '1;
      cmdSync_q  <= '1;
    end else begin
      attSync_q  <= {attSync_q[1:0], iATT};
      pclkSync_q <= {pclkSync_q[1:0], iPCLK};
      cmdSync_q  <= {cmdSync_q[0], iCMD};
    end
  end

  logic attFall, attRise, pclkFall, pclkRise, cmdBit;
  assign attFall  = attSync_q[2] & ~attSync_q[1];
  assign attRise  = ~attSync_q[2] & attSync_q[1];
  assign pclkFall = pclkSync_q[2] & ~pclkSync_q[1];
  assign pclkRise = ~pclkSync_q[2] & pclkSync_q[1];
  assign cmdBit   = cmdSync_q[1];

  function automatic logic [7:0] txByte(input logic [2:0] idx, input logic [15:0] btn);
    case (idx)
      3'd0:    txByte = 8'hFF;
      3'd1:    txByte = PAD_ID;
      3'd2:    txByte = 8'h5A;
      3'd3:    txByte = ~btn[7:0];
      3'd4:    txByte = ~btn[15:8];
      default: txByte = 8'hFF;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [2:0]    bitCnt_q, bitCnt_d;
  logic [2:0]    byteIdx_q, byteIdx_d;
  logic [7:0]    txSr_q, txSr_d;
  logic [7:0]    rxSr_q, rxSr_d;
  logic [15:0]   btnLat_q, btnLat_d;
  logic [7:0]    motorLo_q, motorLo_d;
  logic [15:0]   motor_q, motor_d;
  logic [CW-1:0] ackCnt_q, ackCnt_d;
  logic          byteDone_q, byteDone_d;
  logic          dat_q, dat_d;
  logic          ack_q, ack_d;
  logic          poll_q, poll_d;
  logic          err_q, err_d;

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      byteIdx_q  <= '0;
      txSr_q     <= 8'hFF;
      rxSr_q     <= '0;
      btnLat_q   <= '0;
      motorLo_q  <= '0;
      motor_q    <= '0;
      ackCnt_q   <= '0;
      byteDone_q <= 1'b0;
      dat_q      <= 1'b1;
      ack_q      <= 1'b1;
      poll_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      byteIdx_q  <= byteIdx_d;
      txSr_q     <= txSr_d;
      rxSr_q     <= rxSr_d;
      btnLat_q   <= btnLat_d;
      motorLo_q  <= motorLo_d;
      motor_q    <= motor_d;
      ackCnt_q   <= ackCnt_d;
      byteDone_q <= byteDone_d;
      dat_q      <= dat_d;
      ack_q      <= ack_d;
      poll_q     <= poll_d;
      err_q      <= err_d;
    end
  end

  // An ATT release overrides everything; a completed byte is judged the cycle after its last bit
  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    byteIdx_d  = byteIdx_q;
    txSr_d     = txSr_q;
    rxSr_d     = rxSr_q;
    btnLat_d   = btnLat_q;
    motorLo_d  = motorLo_q;
    motor_d    = motor_q;
    ackCnt_d   = ackCnt_q;
    byteDone_d = byteDone_q;
    dat_d      = dat_q;
    ack_d      = ack_q;
    poll_d     = 1'b0;
    err_d      = 1'b0;

    if (attRise) begin
      state_d    = IDLE;
      bitCnt_d   = '0;
      byteIdx_d  = '0;
      ackCnt_d   = '0;
      byteDone_d = 1'b0;
      dat_d      = 1'b1;
      ack_d      = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          dat_d = 1'b1;
          ack_d = 1'b1;
          if (attFall) begin
            state_d    = SHIFT;
            byteIdx_d  = '0;
            bitCnt_d   = '0;
            txSr_d     = 8'hFF;
            btnLat_d   = iBTN;
            byteDone_d = 1'b0;
          end
        end
        SHIFT: begin
          if (byteDone_q) begin
            byteDone_d = 1'b0;
            if ((byteIdx_q == 3'd0 && rxSr_q != 8'h01) ||
                (byteIdx_q == 3'd1 && rxSr_q != 8'h42)) begin
              err_d   = 1'b1;
              state_d = IGNORE;
              dat_d   = 1'b1;
            end else if (byteIdx_q == 3'd4) begin
              motor_d = {rxSr_q, motorLo_q};
              poll_d  = 1'b1;
              state_d = IGNORE;
              dat_d   = 1'b1;
            end else begin
              if (byteIdx_q == 3'd3) motorLo_d = rxSr_q;
              state_d   = ACK_WAIT;
              ackCnt_d  = '0;
              byteIdx_d = byteIdx_q + 3'd1;
              txSr_d    = txByte(byteIdx_q + 3'd1, btnLat_q);
              dat_d     = 1'b1;
            end
          end else if (pclkFall) begin
            dat_d = txSr_q[bitCnt_q];
          end else if (pclkRise) begin
            rxSr_d[bitCnt_q] = cmdBit;
            bitCnt_d         = bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) byteDone_d = 1'b1;
          end
        end
        ACK_WAIT: begin
          if (pclkFall) begin
            state_d = SHIFT;
            ack_d   = 1'b1;
            dat_d   = txSr_q[0];
          end else if (ackCnt_q == DELAY_LAST) begin
            state_d  = ACK_PULSE;
            ackCnt_d = '0;
            ack_d    = 1'b0;
          end else begin
            ackCnt_d = ackCnt_q + CNT_ONE;
          end
        end
        ACK_PULSE: begin
          if (pclkFall) begin
            state_d = SHIFT;
            ack_d   = 1'b1;
            dat_d   = txSr_q[0];
          end else if (ackCnt_q == WIDTH_LAST) begin
            state_d  = SHIFT;
            ackCnt_d = '0;
            ack_d    = 1'b1;
          end else begin
            ackCnt_d = ackCnt_q + CNT_ONE;
          end
        end
        IGNORE: begin
          dat_d = 1'b1;
          ack_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign oDAT   = dat_q;
  assign oACK   = ack_q;
  assign oPOLL  = poll_q;
  assign oERR   = err_q;
  assign oMOTOR = motor_q;
  assign oBUSY  = (state_q != IDLE);

endmodule

// File: tb/tb_psone_pad.sv
// Testbench for psone_pad: plays the console side of the link and checks
// replies, ACK timing and strobes against a byte-level model of a digital pad.
`timescale 1ns/1ps
module tb_psone_pad;

  localparam logic [7:0] PAD_ID    = 8'h41;
  localparam int         ACK_DELAY = 150;
  localparam int         ACK_WIDTH = 100;

  logic        iCLK   = 1'b0;
  logic        iRESET = 1'b0;
  logic        iATT   = 1'b1;
  logic        iPCLK  = 1'b1;
  logic        iCMD   = 1'b1;
  logic [15:0] iBTN   = 16'h0000;
  logic        oDAT, oACK, oPOLL, oERR, oBUSY;
  logic [15:0] oMOTOR;

  psone_pad #(.PAD_ID(PAD_ID), .ACK_DELAY(ACK_DELAY), .ACK_WIDTH(ACK_WIDTH)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iATT(iATT), .iPCLK(iPCLK), .iCMD(iCMD), .iBTN(iBTN),
    .oDAT(oDAT), .oACK(oACK), .oPOLL(oPOLL), .oMOTOR(oMOTOR), .oERR(oERR), .oBUSY(oBUSY)
  );

  always #10 iCLK = ~iCLK;

  int          checkCount = 0;
  int          errorCount = 0;
  int          ackFalls   = 0;
  int          pollPulses = 0;
  int          errPulses  = 0;
  int          pulseViol  = 0;
  logic        ackPrev    = 1'b1;
  logic        pollPrev   = 1'b0;
  logic        errPrev    = 1'b0;
  logic [15:0] motorModel = 16'h0000;

  // Counts ACK assertions and strobes; flags overlapping or stretched strobes
  always @(negedge iCLK) begin
    if (ackPrev && !oACK) ackFalls++;
    if (oPOLL) pollPulses++;
    if (oERR) errPulses++;
    if ((oPOLL && oERR) || (oPOLL && pollPrev) || (oERR && errPrev)) pulseViol++;
    ackPrev  = oACK;
    pollPrev = oPOLL;
    errPrev  = oERR;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  // One byte LSB-first; DAT is sampled just before each rising edge, PCLK left high after bit 7
  task automatic hostByte(input logic [7:0] cmd, input int half, output logic [7:0] dat);
    for (int b = 0; b < 8; b++) begin
      iPCLK = 1'b0;
      iCMD  = cmd[b];
      waitCycles(half);
      dat[b] = oDAT;
      iPCLK = 1'b1;
      if (b != 7) waitCycles(half);
    end
  endtask

  task automatic honourAck(input string tag);
    int d = 0;
    int w = 0;
    while (oACK === 1'b1 && d < 400) begin
      waitCycles(1);
      d++;
    end
    checkOutput($sformatf("%s_ackDelay", tag), 32'(d >= ACK_DELAY && d <= ACK_DELAY + 8), 32'd1);
    while (oACK === 1'b0 && w < 400) begin
      waitCycles(1);
      w++;
    end
    checkOutput($sformatf("%s_ackWidth", tag), 32'(w), 32'(ACK_WIDTH));
  endtask

  // Full ATT-low transaction of five host bytes, scored against the pad model
  task automatic applyStimulus(input string name, input logic [39:0] cmds, input logic [15:0] btn,
                               input logic changeBtn, input logic [15:0] btnAlt,
                               input logic [3:0] early, input int half);
    logic [7:0] resp [5];
    logic [7:0] got;
    int abortAfter, expAcks, ack0, poll0, err0;
    resp = '{8'hFF, PAD_ID, 8'h5A, ~btn[7:0], ~btn[15:8]};
    if (cmds[7:0] != 8'h01)       abortAfter = 0;
    else if (cmds[15:8] != 8'h42) abortAfter = 1;
    else                          abortAfter = 5;
    expAcks = 0;
    ack0 = ackFalls;
    poll0 = pollPulses;
    err0 = errPulses;
    iBTN = btn;
    iATT = 1'b0;
    waitCycles(10);
    if (changeBtn) iBTN = btnAlt;
    for (int k = 0; k < 5; k++) begin
      hostByte(cmds[8*k +: 8], half, got);
      checkOutput($sformatf("%s_dat%0d", name, k), 32'(got), 32'((k <= abortAfter) ? resp[k] : 8'hFF));
      if (k < 4 && k < abortAfter) begin
        expAcks++;
        if (early[k]) begin
          expAcks--;
          waitCycles(50);
        end else begin
          honourAck($sformatf("%s_b%0d", name, k));
          waitCycles(10);
        end
      end else begin
        waitCycles(200);
      end
    end
    iATT = 1'b1;
    waitCycles(5);
    if (abortAfter == 5) motorModel = {cmds[39:32], cmds[31:24]};
    checkOutput($sformatf("%s_busy", name), 32'(oBUSY), 32'd0);
    checkOutput($sformatf("%s_idleDat", name), 32'(oDAT), 32'd1);
    checkOutput($sformatf("%s_idleAck", name), 32'(oACK), 32'd1);
    checkOutput($sformatf("%s_motor", name), 32'(oMOTOR), 32'(motorModel));
    checkOutput($sformatf("%s_acks", name), 32'(ackFalls - ack0), 32'(expAcks));
    checkOutput($sformatf("%s_polls", name), 32'(pollPulses - poll0), 32'(abortAfter == 5));
    checkOutput($sformatf("%s_errs", name), 32'(errPulses - err0), 32'(abortAfter != 5));
    waitCycles(10);
  endtask

  task automatic abortMidByte();
    logic [7:0] got;
    int poll0, err0;
    iBTN = 16'h1111;
    iATT = 1'b0;
    waitCycles(10);
    hostByte(8'h01, 50, got);
    honourAck("abort_b0");
    waitCycles(10);
    hostByte(8'h42, 50, got);
    honourAck("abort_b1");
    waitCycles(10);
    for (int b = 0; b < 3; b++) begin
      iPCLK = 1'b0;
      iCMD  = 1'b0;
      waitCycles(50);
      iPCLK = 1'b1;
      waitCycles(50);
    end
    checkOutput("abort_preDat", 32'(oDAT), 32'd0);
    poll0 = pollPulses;
    err0  = errPulses;
    iATT  = 1'b1;
    waitCycles(3);
    checkOutput("abort_busy", 32'(oBUSY), 32'd0);
    checkOutput("abort_dat", 32'(oDAT), 32'd1);
    checkOutput("abort_ack", 32'(oACK), 32'd1);
    waitCycles(10);
    checkOutput("abort_noStrobe", 32'((pollPulses - poll0) + (errPulses - err0)), 32'd0);
  endtask

  task automatic resetMidByte();
    logic [7:0] got;
    iATT = 1'b0;
    waitCycles(10);
    hostByte(8'h01, 50, got);
    honourAck("rst_b0");
    waitCycles(10);
    iPCLK = 1'b0;
    iCMD  = 1'b0;
    waitCycles(50);
    iPCLK = 1'b1;
    waitCycles(50);
    iPCLK = 1'b0;
    waitCycles(50);
    checkOutput("rst_preDat", 32'(oDAT), 32'(PAD_ID[1]));
    iRESET = 1'b0;
    #1;
    motorModel = 16'h0000;
    checkOutput("rst_dat", 32'(oDAT), 32'd1);
    checkOutput("rst_ack", 32'(oACK), 32'd1);
    checkOutput("rst_poll", 32'(oPOLL), 32'd0);
    checkOutput("rst_err", 32'(oERR), 32'd0);
    checkOutput("rst_motor", 32'(oMOTOR), 32'(motorModel));
    checkOutput("rst_busy", 32'(oBUSY), 32'd0);
    iATT  = 1'b1;
    iPCLK = 1'b1;
    waitCycles(5);
    iRESET = 1'b1;
    waitCycles(5);
    checkOutput("rst_afterBusy", 32'(oBUSY), 32'd0);
  endtask

  initial begin
    logic [7:0]  c0, c1;
    logic [39:0] cmds;
    int          v;
    waitCycles(3);
    checkOutput("init_dat", 32'(oDAT), 32'd1);
    checkOutput("init_ack", 32'(oACK), 32'd1);
    checkOutput("init_poll", 32'(oPOLL), 32'd0);
    checkOutput("init_err", 32'(oERR), 32'd0);
    checkOutput("init_motor", 32'(oMOTOR), 32'd0);
    checkOutput("init_busy", 32'(oBUSY), 32'd0);
    iRESET = 1'b1;
    waitCycles(5);

    applyStimulus("normal", 40'h55AA004201, 16'h0003, 1'b0, 16'h0000, 4'b0000, 100);
    applyStimulus("badAddr", 40'h55AA004281, 16'h0F0F, 1'b0, 16'h0000, 4'b0000, 50);
    applyStimulus("badCmd", 40'h55AA004301, 16'h0F0F, 1'b0, 16'h0000, 4'b0000, 50);
    applyStimulus("early", 40'h3412004201, 16'h8001, 1'b0, 16'h0000, 4'b0101, 50);
    applyStimulus("btnChange", 40'h6677004201, 16'hA5C3, 1'b1, 16'h5A3C, 4'b0000, 50);
    abortMidByte();
    applyStimulus("postAbort", 40'h2211004201, 16'h00FF, 1'b0, 16'h0000, 4'b0000, 50);

    for (int i = 0; i < 8; i++) begin
      v = $urandom_range(0, 255);
      if (v == 1) v = 2;
      c0 = ($urandom_range(0, 3) == 0) ? v[7:0] : 8'h01;
      v = $urandom_range(0, 255);
      if (v == 'h42) v = 'h43;
      c1 = ($urandom_range(0, 3) == 0) ? v[7:0] : 8'h42;
      cmds = {8'($urandom), 8'($urandom), 8'($urandom), c1, c0};
      applyStimulus($sformatf("rand%0d", i), cmds, 16'($urandom), 1'($urandom_range(0, 1)),
                    16'($urandom), 4'($urandom_range(0, 15)), 20);
    end

    applyStimulus("final", 40'hBEEF004201, 16'h1234, 1'b0, 16'h0000, 4'b0000, 20);
    resetMidByte();

    checkOutput("pulseRules", 32'(pulseViol), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/psone_pad.md
Name: psone_pad

Overview:
- PlayStation controller emulator: the responder end of the console/pad serial link (ATT, CLK, CMD in; DAT, ACK out).
- Samples the host bit stream LSB-first and answers a standard digital-pad poll (01/42/00/xx/xx) with ID 0x41, 0x5A and two button bytes.
- Generates the ACK low pulse after each byte except the last, and reports received motor bytes to the fabric.
- Sits at the top level behind open-drain pad drivers, fed by the button-source logic.

Parameters:
- PAD_ID, 8'h41, ID byte returned during byte 1 (digital pad).
- ACK_DELAY, 150, iCLK cycles from byte completion to ACK assertion.
- ACK_WIDTH, 100, iCLK cycles ACK is held low.

Ports:
- iCLK  in  1  system clock (50 MHz nominal).
- iRESET  in  1  asynchronous, active-low reset.
- iATT  in  1  host attention/select, active-low, asynchronous to iCLK.
- iPCLK  in  1  host serial clock, idles high, asynchronous.
- iCMD  in  1  host command data, asynchronous.
- iBTN  in  16  button states, 1 = pressed; bit order equals wire order.
- oDAT  out  1  pad data; 1 = released (top level converts to Z).
- oACK  out  1  acknowledge, active-low; 1 = released.
- oPOLL  out  1  one-cycle strobe when a full 5-byte poll completes.
- oMOTOR  out  16  {byte4, byte3} received from host; updated with oPOLL.
- oERR  out  1  one-cycle strobe when a transaction is aborted on a bad header byte.
- oBUSY  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, iRESET low): oDAT=1, oACK=1, oPOLL=0, oERR=0, oMOTOR=0, oBUSY=0, state=IDLE, all counters 0.
- Synchronizers: iATT, iPCLK and iCMD pass through 2-flop synchronizers, reset to 1. Edge detection uses the synchronized values; latency from pin to reaction is 3 iCLK cycles.
- Transmit bytes by index:
  - byte 0: 0xFF.
  - byte 1: PAD_ID.
  - byte 2: 0x5A.
  - byte 3: ~btn_lat[7:0].
  - byte 4: ~btn_lat[15:8].
- Buttons are latched into btn_lat on the ATT falling edge.
- States:
  - IDLE: oDAT=1, oACK=1.
    - ATT falling → SHIFT, byte_idx=0, bit_cnt=0, tx_sr=0xFF, latch iBTN.
    - If ATT is low at reset release, this counts as a falling edge.
  - SHIFT:
    - PCLK falling: oDAT <= tx_sr[bit_cnt].
    - PCLK rising: rx_sr[bit_cnt] <= CMD, bit_cnt++.
    - On the 8th rising edge (bit_cnt wraps 7→0) the byte is complete and the next cycle evaluates it:
      - byte 0 with rx != 0x01, or byte 1 with rx != 0x42 → oERR pulse, → IGNORE.
      - byte 3 → store rx in motor_lo.
      - byte 4 → oMOTOR <= {rx, motor_lo}, oPOLL pulse, → IGNORE (no ACK on the last byte).
      - otherwise → ACK_WAIT; byte_idx++, tx_sr loaded with the next byte, oDAT=1 (released between bytes).
  - ACK_WAIT: count ACK_DELAY cycles → ACK_PULSE.
  - ACK_PULSE: oACK=0 for ACK_WIDTH cycles, then oACK=1 → SHIFT.
  - IGNORE: oDAT=1, oACK=1; wait for ATT high.
- PCLK falling during ACK_WAIT/ACK_PULSE (host did not wait): release oACK the same cycle, enter SHIFT, and process the edge as that byte's first falling edge (oDAT <= tx_sr[0]).
- ATT rising in any state: → IDLE next cycle. oDAT=1, oACK=1, counters cleared, no oPOLL/oERR generated. This is the mid-transaction abort path.
- PCLK edges while ATT is high are ignored.
- oPOLL and oERR are mutually exclusive and never asserted for more than one cycle.
- Counters: ACK counter is ceil(log2(max(ACK_DELAY, ACK_WIDTH)+1)) bits, cleared on entry to each ACK state. bit_cnt is 3 bits; byte_idx is 3 bits, range 0..4.

Test Plan:
- Normal poll: host sends 01 42 00 AA 55 (4 µs bit period, ACK honoured) with iBTN=16'h0003. Expect:
  - DAT bytes FF 41 5A FC FF.
  - Four ACK pulses of 100 cycles, each starting 150 cycles after the byte.
  - No ACK after byte 4.
  - oPOLL once, oMOTOR=16'h55AA.
- Wrong address: host byte 0 = 0x81. Expect oERR pulse, no ACK, DAT stays 1 for the rest of ATT-low, oPOLL=0, oMOTOR unchanged.
- Wrong command: 01 then 0x43. Expect DAT FF,41, one ACK after byte 0, then oERR, no further ACK/DAT activity.
- Mid-transaction ATT release after 3 bits of byte 2. Expect IDLE within 3 cycles, oDAT=1, oACK=1, oBUSY=0. A following full poll succeeds.
- Host ignores ACK: next byte's first PCLK fall arrives 50 cycles after byte completion. Expect oACK never asserted (or released immediately) and a correct DAT bit 0 for that byte.
- Button change mid-poll: iBTN changes after the ATT fall. Expect the transmitted bytes to reflect the value latched at the ATT fall. Assert iRESET mid-byte: all outputs return to reset values immediately.
